plot_sink_fb: RTL and testbench



---
 rtl/plot_sink_if.sv | 41 ++++
 rtl/plot_sink_fb.sv | 160 ++++++++++++++++
 tb/tb_plot_sink_fb.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/plot_sink_if.sv
// Plot-stream and scan-out signal bundle for plot_sink_fb.
// wr_count exists only when PLOT_SINK_WRCOUNT_EN is defined.
interface plot_sink_if;
  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned COL_W = 3;
  localparam int unsigned DROP_W = 8;

  logic             plot;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour;
  logic             plot_ready;
  logic             scan_start;
  logic             scan_busy;
  logic             rd_valid;
  logic [X_W-1:0]   rd_x;
  logic [Y_W-1:0]   rd_y;
  logic [COL_W-1:0] rd_colour;
  logic             scan_done;
  logic [DROP_W-1:0] dropped;
`ifdef PLOT_SINK_WRCOUNT_EN
  logic [15:0]      wr_count;
`endif

  modport master (
    output plot, x, y, colour, scan_start,
    input  plot_ready, scan_busy, rd_valid, rd_x, rd_y, rd_colour, scan_done, dropped
`ifdef PLOT_SINK_WRCOUNT_EN
    , input wr_count
`endif
  );

  modport slave (
    input  plot, x, y, colour, scan_start,
    output plot_ready, scan_busy, rd_valid, rd_x, rd_y, rd_colour, scan_done, dropped
`ifdef PLOT_SINK_WRCOUNT_EN
    , output wr_count
`endif
  );
endinterface

// File: rtl/plot_sink_fb.sv
// Plot sink: queues in-range plots, commits them to a 160x120x3 framebuffer, scans it out in raster order.
// Optional PLOT_SINK_WRCOUNT_EN adds a committed-write counter (wr_count).
module plot_sink_fb #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_RES      = 160,
  parameter int unsigned V_RES      = 120
) (
  input logic       clk,
  input logic       reset,
  plot_sink_if.slave bus
);
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PIX_N  = H_RES * V_RES;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  colour;
  } plot_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} scan_state_t;

  plot_entry_t       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [COL_W-1:0]  r_mem [PIX_N];

  scan_state_t       r_state;
  logic              r_scan_busy;
  logic [X_W-1:0]    r_cx;
  logic [Y_W-1:0]    r_cy;
  logic              r_rd_valid;
  logic [X_W-1:0]    r_rd_x;
  logic [Y_W-1:0]    r_rd_y;
  logic [COL_W-1:0]  r_rd_colour;
  logic              r_scan_done;
  logic [7:0]        r_dropped;

  logic              w_full, w_empty, w_accept, w_in_range, w_push, w_pop;
  logic [ADDR_W-1:0] w_plot_addr, w_scan_addr;
  plot_entry_t       w_head;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_accept    = bus.plot && !w_full;
  assign w_in_range  = ({1'b0, bus.x} < 9'(H_RES)) && ({1'b0, bus.y} < 8'(V_RES));
  assign w_push      = w_accept && w_in_range;
  // Scan owns the RAM port for its whole duration, so writes wait while busy.
  assign w_pop       = !r_scan_busy && !w_empty;
  assign w_plot_addr = (ADDR_W'(bus.y) << 7) + (ADDR_W'(bus.y) << 5) + ADDR_W'(bus.x);
  assign w_scan_addr = (ADDR_W'(r_cy) << 7) + (ADDR_W'(r_cy) << 5) + ADDR_W'(r_cx);
  assign w_head      = r_fifo[r_rd_ptr];

  // Plot FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= '{addr: w_plot_addr, colour: bus.colour};
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Framebuffer write port; contents are never cleared
  always_ff @(posedge clk) begin
    if (w_pop && !reset) r_mem[w_head.addr] <= w_head.colour;
  end

  // Scan-out reader: address counter runs one cycle ahead of the output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_scan_busy <= 1'b0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_x      <= '0;
      r_rd_y      <= '0;
      r_rd_colour <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_rd_valid  <= 1'b0;
      r_scan_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.scan_start) begin
            r_state     <= S_READ;
            r_scan_busy <= 1'b1;
            r_cx        <= '0;
            r_cy        <= '0;
          end
        end
        S_READ: begin
          r_rd_valid  <= 1'b1;
          r_rd_x      <= r_cx;
          r_rd_y      <= r_cy;
          r_rd_colour <= r_mem[w_scan_addr];
          if (r_cx == X_W'(H_RES - 1)) begin
            r_cx <= '0;
            if (r_cy == Y_W'(V_RES - 1)) begin
              r_cy        <= '0;
              r_state     <= S_DRAIN;
              r_scan_done <= 1'b1;
            end else begin
              r_cy <= r_cy + Y_W'(1);
            end
          end else begin
            r_cx <= r_cx + X_W'(1);
          end
        end
        S_DRAIN: begin
          r_state     <= S_IDLE;
          r_scan_busy <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_scan_busy <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range plots are consumed but only counted
  always_ff @(posedge clk) begin
    if (reset) r_dropped <= '0;
    else if (w_accept && !w_in_range && r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
  end

`ifdef PLOT_SINK_WRCOUNT_EN
  logic [15:0] r_wr_count;
  logic        w_cnt_clear;
  assign w_cnt_clear = bus.scan_start && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset)            r_wr_count <= '0;
    else if (w_cnt_clear) r_wr_count <= 16'(w_pop);
    else                  r_wr_count <= r_wr_count + 16'(w_pop);
  end
  assign bus.wr_count = r_wr_count;
`endif

  assign bus.plot_ready = !w_full;
  assign bus.scan_busy  = r_scan_busy;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_x       = r_rd_x;
  assign bus.rd_y       = r_rd_y;
  assign bus.rd_colour  = r_rd_colour;
  assign bus.scan_done  = r_scan_done;
  assign bus.dropped    = r_dropped;
endmodule

// File: tb/tb_plot_sink_fb.sv
// Bench for plot_sink_fb: framebuffer/queue/scan-timeline model checked every cycle plus directed literal checks.
module tb_plot_sink_fb;
  localparam int unsigned PIX = 160 * 120;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  plot_sink_if bus();
  plot_sink_fb dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: framebuffer image, pending-plot queue, scan timeline as pixel indices
  int       fb [PIX];
  bit       known [PIX];
  int       q_a [$];
  int       q_c [$];
  bit       m_started = 0;
  bit       m_busy = 0;
  int       m_issue = -1;
  int       m_out = -1;
  int       m_out_col = 0;
  bit       m_out_known = 0;
  int       m_dropped = 0;

  always @(posedge clk) begin : model_b
    int sz;
    if (reset) begin
      m_started = 1;
      m_busy = 0; m_issue = -1; m_out = -1; m_dropped = 0;
      q_a.delete(); q_c.delete();
    end else begin
      sz = q_a.size();
      if (!m_busy && sz > 0) begin
        fb[q_a[0]] = q_c[0];
        known[q_a[0]] = 1;
        void'(q_a.pop_front());
        void'(q_c.pop_front());
      end
      if (bus.plot && sz < 4) begin
        if (int'(bus.x) < 160 && int'(bus.y) < 120) begin
          q_a.push_back(int'(bus.y) * 160 + int'(bus.x));
          q_c.push_back(int'(bus.colour));
        end else if (m_dropped < 255) m_dropped++;
      end
      if (m_issue >= 0) begin
        m_out = m_issue; m_out_col = fb[m_issue]; m_out_known = known[m_issue];
      end else m_out = -1;
      if (m_busy) begin
        if (m_issue < 0) m_busy = 0;
        else if (m_issue == PIX - 1) m_issue = -1;
        else m_issue++;
      end else if (bus.scan_start) begin
        m_busy = 1; m_issue = 0;
      end
    end
  end

  int n_valid = 0, n_done = 0, n_fall = 0;
  bit prev_busy = 0;
  int cap37 = -1, cap1010 = -1, done_x = -1, done_y = -1;

  always @(negedge clk) begin
    if (m_started) begin
      chk("plot_ready", int'(bus.plot_ready), int'(q_a.size() < 4));
      chk("scan_busy", int'(bus.scan_busy), int'(m_busy));
      chk("rd_valid", int'(bus.rd_valid), int'(m_out >= 0));
      chk("scan_done", int'(bus.scan_done), int'(m_out == PIX - 1));
      chk("dropped", int'(bus.dropped), m_dropped);
      if (m_out >= 0) begin
        chk("rd_x", int'(bus.rd_x), m_out % 160);
        chk("rd_y", int'(bus.rd_y), m_out / 160);
        if (m_out_known) chk("rd_colour", int'(bus.rd_colour), m_out_col);
      end
    end
    if (bus.rd_valid) begin
      n_valid++;
      if (bus.rd_x == 8'd3 && bus.rd_y == 7'd7) cap37 = int'(bus.rd_colour);
      if (bus.rd_x == 8'd10 && bus.rd_y == 7'd10) cap1010 = int'(bus.rd_colour);
    end
    if (bus.scan_done) begin
      n_done++; done_x = int'(bus.rd_x); done_y = int'(bus.rd_y);
    end
    if (prev_busy && !bus.scan_busy) n_fall++;
    prev_busy = bus.scan_busy;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic plot_one(input int px, input int py, input int pc);
    bus.plot = 1'b1; bus.x = 8'(px); bus.y = 7'(py); bus.colour = 3'(pc);
    tick();
    bus.plot = 1'b0;
  endtask

  task automatic pulse_start();
    bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
  endtask

  task automatic wait_scan_end();
    for (int k = 0; k < 25000 && bus.scan_busy; k++) tick();
    chk("scan_end_timeout", int'(bus.scan_busy), 0);
  endtask

  task automatic clear_counts();
    n_valid = 0; n_done = 0; n_fall = 0;
  endtask

  initial begin
    int n_acc;
    bit found;
    bus.plot = 1'b0; bus.x = '0; bus.y = '0; bus.colour = '0; bus.scan_start = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_plot_ready", int'(bus.plot_ready), 1);
    chk("reset_rd_colour", int'(bus.rd_colour), 0);

    // Corners, then (3,7) accepted the cycle before scan_start: 1-cycle write latency
    plot_one(0, 0, 5);
    plot_one(159, 119, 7);
    plot_one(159, 0, 2);
    plot_one(0, 119, 4);
    plot_one(3, 7, 3);
    clear_counts();
    pulse_start();
    wait_scan_end();
    tick();
    chk("pix_3_7", cap37, 3);
    chk("done_x", done_x, 159);
    chk("done_y", done_y, 119);
    chk("scan1_valid_cnt", n_valid, 19200);
    chk("scan1_done_cnt", n_done, 1);

    // Out-of-range plots
    plot_one(160, 5, 1);
    plot_one(0, 120, 2);
    chk("dropped_2", int'(bus.dropped), 2);
    chk("ready_after_drop", int'(bus.plot_ready), 1);

    // Plot every cycle during a scan, plus a redundant scan_start mid-scan
    clear_counts();
    pulse_start();
    n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      bus.plot = 1'b1; bus.x = 8'(20 + i); bus.y = 7'd50; bus.colour = 3'(i + 1);
      if (bus.plot_ready) n_acc++;
      tick();
    end
    bus.plot = 1'b0;
    chk("accepted_during_scan", n_acc, 4);
    repeat (1000) tick();
    pulse_start();
    wait_scan_end();
    tick();
    chk("scan2_valid_cnt", n_valid, 19200);
    chk("scan2_busy_falls", n_fall, 1);
    chk("scan2_done_cnt", n_done, 1);
    repeat (3) tick();
    chk("fifo_drained", int'(bus.plot_ready), 1);

    // Same pixel twice: last write wins; also rescans the four queued plots
    plot_one(10, 10, 1);
    plot_one(10, 10, 6);
    tick();
    clear_counts();
    pulse_start();
    wait_scan_end();
    tick();
    chk("pix_10_10", cap1010, 6);

    // Reset in the middle of a scan at pixel 500 = (20,3)
    pulse_start();
    found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      if (bus.rd_valid && bus.rd_x == 8'd20 && bus.rd_y == 7'd3) found = 1;
      else tick();
    end
    chk("pix500_reached", int'(found), 1);
    reset = 1'b1;
    tick();
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_scan_busy", int'(bus.scan_busy), 0);
    chk("rst_plot_ready", int'(bus.plot_ready), 1);
    chk("rst_dropped", int'(bus.dropped), 0);
    chk("rst_rd_x", int'(bus.rd_x), 0);
    reset = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
